// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional feature macro: PREFETCH_PERF_EN (drop counter).
package fetch_pkg;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_REQ  = 2'd1,
        PF_DROP = 2'd2
    } pf_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// Circular buffer of {PC, instruction} pairs; flush beats push and pop.
// Storage is not reset; only pointers and count are.
module prefetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge Clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth: pointer overflow is the modulo wrap.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: one-outstanding fetch FSM feeding a small FIFO.
// Define PREFETCH_PERF_EN to add the saturating DropCount output.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [DW-1:0] RESET_PC = DW'(DEFAULT_RESET_PC)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Redirect,
    input  logic [DW-1:0] RedirectPC,
    input  logic          StallF,
    output logic [DW-1:0] InstrF,
    output logic [DW-1:0] PCF,
    output logic          InstrValid,
    output logic          MemReq,
    output logic [DW-1:0] MemAddr,
    input  logic          MemAck,
    input  logic [DW-1:0] MemRData
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]   DropCount
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_t       state;
    logic [DW-1:0]   fetch_pc;
    logic [DW-1:0]   pc_inc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   next_count;
    logic [2*DW-1:0] head;
    logic            ack;
    logic            push;
    logic            pop;
    logic            room;

    assign ack        = MemReq && MemAck;
    assign InstrValid = (count != '0);
    assign pop        = InstrValid && !StallF && !Redirect;
    assign push       = (state == PF_REQ) && ack && !Redirect;
    assign next_count = count + CW'(push) - CW'(pop);
    assign room       = (next_count < CW'(DEPTH));
    assign pc_inc     = fetch_pc + DW'(1);

    prefetch_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .flush (Redirect),
        .wdata ({MemAddr, MemRData}),
        .count (count),
        .head  (head)
    );

    assign InstrF = InstrValid ? head[DW-1:0] : DW'(NOP_INSTR);
    assign PCF    = InstrValid ? head[2*DW-1:DW] : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= PF_IDLE;
            fetch_pc <= RESET_PC;
            MemReq   <= 1'b0;
            MemAddr  <= RESET_PC;
        end else begin
            unique case (state)
                PF_IDLE: begin
                    if (Redirect) begin
                        fetch_pc <= RedirectPC;
                        MemAddr  <= RedirectPC;
                    end else if (room) begin
                        state   <= PF_REQ;
                        MemReq  <= 1'b1;
                        MemAddr <= fetch_pc;
                    end
                end
                PF_REQ: begin
                    if (Redirect) begin
                        fetch_pc <= RedirectPC;
                        if (ack) begin
                            state   <= PF_IDLE;
                            MemReq  <= 1'b0;
                            MemAddr <= RedirectPC;
                        end else begin
                            state <= PF_DROP;
                        end
                    end else if (ack) begin
                        fetch_pc <= pc_inc;
                        MemAddr  <= pc_inc;
                        if (!room) begin
                            state  <= PF_IDLE;
                            MemReq <= 1'b0;
                        end
                    end
                end
                PF_DROP: begin
                    // The stale address stays on the bus until its ack.
                    if (Redirect) fetch_pc <= RedirectPC;
                    if (ack) begin
                        state   <= PF_IDLE;
                        MemReq  <= 1'b0;
                        MemAddr <= Redirect ? RedirectPC : fetch_pc;
                    end
                end
                default: begin
                    state  <= PF_IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef PREFETCH_PERF_EN
    logic drop;

    assign drop = ack && ((state == PF_REQ && Redirect) || state == PF_DROP);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            DropCount <= '0;
        end else if (drop && DropCount != 16'hFFFF) begin
            DropCount <= DropCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: queue-level reference model plus directed scenarios.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Rst;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        StallF;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        InstrValid;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRData;
`ifdef PREFETCH_PERF_EN
    logic [15:0] DropCount;
`endif

    logic        ack_on;
    logic        hold_en;
    logic [31:0] hold_addr;

    int checks = 0;
    int errors = 0;

    fetch_prefetch_queue #(
        .DW       (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .StallF     (StallF),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .InstrValid (InstrValid),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemRData   (MemRData)
`ifdef PREFETCH_PERF_EN
        ,
        .DropCount  (DropCount)
`endif
    );

    // Memory returns address+100; ack can be withheld for one address.
    assign MemRData = MemAddr + 32'd100;
    assign MemAck   = ack_on && !(hold_en && MemAddr == hold_addr);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] exp_pc = 32'h0;
    logic        stale = 1'b0;
    logic [31:0] stale_addr = 32'h0;
    int          drops = 0;

    // Reference model: queue contents from the handshakes seen at each edge.
    initial begin
        logic hs;
        forever begin
            @(posedge Clk or posedge Rst);
            if (Rst) begin
                mq.delete();
                exp_pc = 32'h0;
                stale  = 1'b0;
                drops  = 0;
            end else begin
                hs = MemReq && MemAck;
                if (Redirect) begin
                    mq.delete();
                    exp_pc = RedirectPC;
                    if (hs) begin
                        drops++;
                        stale = 1'b0;
                    end else if (MemReq) begin
                        if (!stale) stale_addr = MemAddr;
                        stale = 1'b1;
                    end
                end else begin
                    if (mq.size() != 0 && !StallF) void'(mq.pop_front());
                    if (hs) begin
                        if (stale) begin
                            stale = 1'b0;
                            drops++;
                        end else begin
                            mq.push_back(ent_t'{MemAddr, MemRData});
                            exp_pc = exp_pc + 32'd1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge Clk);
            chk("m_valid", InstrValid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_pcf", PCF, mq[0].pc);
                chk("m_instr", InstrF, mq[0].instr);
            end else begin
                chk("m_pcf_empty", PCF, 32'h0);
                chk("m_instr_empty", InstrF, 32'h0);
            end
            if (MemReq && !stale) chk("m_addr", MemAddr, exp_pc);
            if (stale) begin
                chk("m_drop_req", MemReq, 1'b1);
                chk("m_drop_addr", MemAddr, stale_addr);
            end
            if (mq.size() == DEPTH) chk("m_full_noreq", MemReq, 1'b0);
`ifdef PREFETCH_PERF_EN
            chk("m_dropcount", DropCount, drops);
`endif
        end
    end

    initial begin
        Rst        = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        StallF     = 1'b0;
        ack_on     = 1'b0;
        hold_en    = 1'b0;
        hold_addr  = 32'h0;

        // Reset values, then streaming with ack tied high
        repeat (2) @(negedge Clk);
        chk("rst_req", MemReq, 1'b0);
        chk("rst_addr", MemAddr, 32'h0);
        chk("rst_valid", InstrValid, 1'b0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pcf", PCF, 32'h0);
        Rst    = 1'b0;
        ack_on = 1'b1;
        @(negedge Clk);
        chk("t1_req", MemReq, 1'b1);
        chk("t1_addr", MemAddr, 32'h0);
        chk("t1_valid", InstrValid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("t1_pcf", PCF, i);
            chk("t1_instr", InstrF, 100 + i);
        end

        // Stall until full, then drain 0..5
        #2 Rst = 1'b1;
        StallF = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);
        chk("t2_full_req", MemReq, 1'b0);
        chk("t2_full_addr", MemAddr, 32'h4);
        chk("t2_full_pcf", PCF, 32'h0);
        @(negedge Clk);
        chk("t2_hold_req", MemReq, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("t2_drain_valid", InstrValid, 1'b1);
            chk("t2_drain_pcf", PCF, i);
            chk("t2_drain_instr", InstrF, 100 + i);
            StallF = 1'b0;
            @(negedge Clk);
        end

        // Late ack on addr 2 with a redirect to 0x40 while waiting
        #2 Rst = 1'b1;
        hold_en   = 1'b1;
        hold_addr = 32'h2;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        Redirect   = 1'b1;
        RedirectPC = 32'h40;
        @(negedge Clk);
        Redirect = 1'b0;
        chk("t3_drop_req", MemReq, 1'b1);
        chk("t3_drop_addr", MemAddr, 32'h2);
        chk("t3_drop_valid", InstrValid, 1'b0);
        @(negedge Clk);
        hold_en = 1'b0;
        @(negedge Clk);
        chk("t3_idle_req", MemReq, 1'b0);
        chk("t3_idle_valid", InstrValid, 1'b0);
        @(negedge Clk);
        chk("t3_new_req", MemReq, 1'b1);
        chk("t3_new_addr", MemAddr, 32'h40);
        @(negedge Clk);
        chk("t3_first_pcf", PCF, 32'h40);
        chk("t3_first_instr", InstrF, 32'hA4);
`ifdef PREFETCH_PERF_EN
        chk("t3_dropcount", DropCount, 16'd1);
`endif

        // Redirect to 0x80 coinciding with an ack and a pop
        Redirect   = 1'b1;
        RedirectPC = 32'h80;
        @(negedge Clk);
        Redirect = 1'b0;
        chk("t4_valid", InstrValid, 1'b0);
        chk("t4_req", MemReq, 1'b0);
        @(negedge Clk);
        chk("t4_new_req", MemReq, 1'b1);
        chk("t4_new_addr", MemAddr, 32'h80);
        @(negedge Clk);
        chk("t4_pcf", PCF, 32'h80);
        chk("t4_instr", InstrF, 32'hE4);
`ifdef PREFETCH_PERF_EN
        chk("t4_dropcount", DropCount, 16'd2);
`endif

        // Asynchronous reset with three entries queued
        StallF = 1'b1;
        repeat (2) @(negedge Clk);
        chk("t5_pre_pcf", PCF, 32'h80);
        chk("t5_pre_addr", MemAddr, 32'h83);
        #2 Rst = 1'b1;
        #1;
        chk("t5_rst_valid", InstrValid, 1'b0);
        chk("t5_rst_req", MemReq, 1'b0);
        chk("t5_rst_addr", MemAddr, 32'h0);
        chk("t5_rst_pcf", PCF, 32'h0);
        StallF = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("t5_req", MemReq, 1'b1);
        chk("t5_addr", MemAddr, 32'h0);

        // Back-to-back redirects while a stale request is pending
        hold_en    = 1'b1;
        hold_addr  = 32'h0;
        Redirect   = 1'b1;
        RedirectPC = 32'h10;
        @(negedge Clk);
        RedirectPC = 32'h20;
        chk("t6_drop_req", MemReq, 1'b1);
        chk("t6_drop_addr", MemAddr, 32'h0);
        @(negedge Clk);
        Redirect = 1'b0;
        hold_en  = 1'b0;
        @(negedge Clk);
        chk("t6_idle_req", MemReq, 1'b0);
        @(negedge Clk);
        chk("t6_new_req", MemReq, 1'b1);
        chk("t6_new_addr", MemAddr, 32'h20);
        @(negedge Clk);
        chk("t6_pcf", PCF, 32'h20);
        chk("t6_instr", InstrF, 32'h84);
`ifdef PREFETCH_PERF_EN
        chk("t6_dropcount", DropCount, 16'd1);
`endif

        repeat (4) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch queue between a multi-cycle instruction memory and the processor's fetch stage. Replaces the direct PC-to-instruction-memory path: it issues word-addressed fetch requests ahead of the core, buffers up to DEPTH {PC, instruction} pairs, and presents the head entry to the IF/ID pipeline register. Branch redirects (PCSrcD) flush the queue and discard any in-flight response. StallF holds the head entry in place.

## Interface
- DW, 32, data/address width; the PC is word-addressed and increments by 1
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Redirect  in  1  branch taken in decode (PCSrcD); flushes the queue
- RedirectPC  in  DW  new fetch address (PCBranchD)
- StallF  in  1  core not accepting; head entry is held
- InstrF  out  DW  head instruction; 32'h0 (NOP) when empty
- PCF  out  DW  PC of head instruction; 0 when empty
- InstrValid  out  1  head entry valid
- MemReq  out  1  fetch request, registered
- MemAddr  out  DW  fetch word address, registered
- MemAck  in  1  memory response; completes the request on a rising edge where MemReq && MemAck
- MemRData  in  DW  instruction word, valid with MemAck

## Operation
- State machine, one outstanding request maximum:
  - IDLE: MemReq=0. Moves to REQ when nextCount < DEPTH. MemAddr then equals FetchPC.
  - REQ: MemReq=1. MemAddr stays stable until ack. On ack: push {MemAddr, MemRData}, FetchPC+1. Stays in REQ with MemAddr=FetchPC+1 if nextCount < DEPTH, else goes to IDLE.
  - DROP: MemReq=1 and the stale address is held. A request is never withdrawn. On ack the data is discarded and the state goes to IDLE.
- nextCount = count + push − pop, computed in the same cycle.
- Pop happens when InstrValid && !StallF. The head advances at the clock edge.
- Redirect is handled at the edge:
  - Queue count is set to 0. FetchPC is set to RedirectPC. A pop in the same cycle is ignored.
  - From IDLE: go to IDLE; the new request is issued the next cycle.
  - From REQ without ack: go to DROP.
  - From REQ with ack in the same cycle: the data is not pushed; go to IDLE.
  - From DROP: stay in DROP, with FetchPC updated to the latest RedirectPC.
- Full (count==DEPTH): no request is issued. The head is still presented.
- Empty: InstrValid=0, InstrF=0, PCF=0.
- Pointer wrap-around is modulo DEPTH. The count is kept in log2(DEPTH)+1 bits.
- Rst, asynchronous, mid-operation:
  - State goes to IDLE, count to 0, pointers to 0, FetchPC to RESET_PC.
  - MemReq=0, MemAddr=RESET_PC, InstrValid=0.
  - A pending memory transaction is abandoned. The memory is reset by the same Rst.

## Timing
- Reset values: MemReq 0, MemAddr RESET_PC, InstrValid 0, InstrF 0, PCF 0.
- First MemReq is high in the cycle after the first rising edge with Rst low.
- Ack at edge k: InstrValid is high and InstrF/PCF are valid after edge k. Load-to-use latency is 1 cycle from ack.
- With MemAck tied high, throughput is 1 instruction per cycle after a 2-cycle startup.
- Redirect at edge k with no request in flight: MemReq at RedirectPC after edge k+1. The first valid instruction follows its ack.
- Outputs are registered or driven from the queue head only. There is no combinational path from MemAck/MemRData to InstrF.

## Configuration
- PREFETCH_PERF_EN defined:
  - Adds output DropCount (16 bits, reset 0).
  - It counts responses discarded in DROP or on a same-cycle Redirect+ack, and saturates at 16'hFFFF.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg:
  - state enum: PF_IDLE, PF_REQ, PF_DROP
  - NOP_INSTR = 32'h0
  - default RESET_PC
- Sub-module prefetch_fifo:
  - circular buffer of DEPTH × (2·DW)
  - push/pop/flush inputs; count, head outputs
  - flush has priority over push and pop
- The FSM, FetchPC and the memory interface stay in fetch_prefetch_queue.

## Test plan
- Reset, then MemAck held high with MemRData = address+100: MemReq appears the cycle after reset release. PCF/InstrF then read 0/100, 1/101, 2/102 on consecutive cycles.
- StallF held high for 6 cycles, MemAck high: the queue fills to 4. MemReq drops with MemAddr=4. PCF holds at 0. On StallF release, PCs 0..5 are delivered without gaps or duplicates.
- MemAck delayed 3 cycles on addr 2, Redirect to 0x40 during the wait: the addr-2 response is discarded. The next MemReq is to 0x40. The first valid PCF is 0x40. DropCount reads 1 with PREFETCH_PERF_EN.
- Redirect to 0x80 in the same cycle as an ack and a pop: neither entry appears. InstrValid is 0 the next cycle. The next request is to 0x80.
- Rst asserted mid-REQ with 3 entries queued: immediately InstrValid=0 and MemReq=0. After release the first request is to RESET_PC.
- Back-to-back Redirects (0x10, then 0x20 the next cycle) while in DROP: only 0x20 is requested after the drop ack.
